serial_seq_gen: RTL and testbench

- Serial frame transmitter; the driving end of the single-bit x line consumed by the team's Moore "101" sequence detector (fsm_moore).
- Accepts a parallel WIDTH-bit word through a valid/ready handshake.
- Emits a fixed 3-bit preamble 1,0,1, then the word MSB-first, then an idle gap.
- Output bits are qualified by x_valid.

---
 rtl/serial_seq_gen.sv | 128 ++++++++++++
 tb/tb_serial_seq_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_seq_gen.sv
// Serial frame transmitter: preamble 1,0,1 then WIDTH data bits MSB-first, then GAP_CYCLES idle.
// First bit appears the cycle after load&&ready; ready is high only in IDLE, so load is ignored mid-frame.
module serial_seq_gen #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  localparam int MAX_A = (WIDTH > 3) ? WIDTH : 3;
  localparam int MAXV  = (GAP_CYCLES > MAX_A) ? GAP_CYCLES : MAX_A;
  localparam int CW    = $clog2(MAXV + 1);

  localparam logic [CW-1:0] LAST_PRE  = CW'(2);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_DONE = CW'((WIDTH >= 2) ? (WIDTH - 2) : 0);
  localparam logic [CW-1:0] LAST_GAP  = CW'((GAP_CYCLES >= 1) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_x;
  logic             r_xv;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_x_nxt;
  logic             w_xv_nxt;
  logic             w_done_nxt;

  // Outputs are computed for the bit presented after the coming edge, then registered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_x_nxt     = 1'b0;
    w_xv_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_state_nxt = S_PRE;
          w_cnt_nxt   = '0;
          w_shift_nxt = din;
          w_x_nxt     = 1'b1;
          w_xv_nxt    = 1'b1;
        end
      end
      S_PRE: begin
        w_xv_nxt = 1'b1;
        if (r_cnt == LAST_PRE) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_x_nxt     = r_shift[WIDTH-1];
          w_shift_nxt = r_shift << 1;
          w_done_nxt  = (WIDTH == 1);
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          w_x_nxt   = (r_cnt != '0);
        end
      end
      S_DATA: begin
        if (r_cnt == LAST_DATA) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          w_xv_nxt    = 1'b1;
          w_cnt_nxt   = r_cnt + CW'(1);
          w_x_nxt     = r_shift[WIDTH-1];
          w_shift_nxt = r_shift << 1;
          w_done_nxt  = (r_cnt == LAST_DONE);
        end
      end
      S_GAP: begin
        if (r_cnt == LAST_GAP) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_x     <= 1'b0;
      r_xv    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_x     <= w_x_nxt;
      r_xv    <= w_xv_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign x       = r_x;
  assign x_valid = r_xv;
  assign done    = r_done;

endmodule

// File: tb/tb_serial_seq_gen.sv
// Directed bench for serial_seq_gen: WIDTH=8/GAP=1 instance plus WIDTH=4/GAP=0 instance, with a behavioural "101" Moore detector on the loopback.
module tb_serial_seq_gen;

  logic       clk;
  logic       rst;
  logic       a_load, b_load;
  logic [7:0] a_din;
  logic [3:0] b_din;
  logic       a_ready, a_x, a_xv, a_done;
  logic       b_ready, b_x, b_xv, b_done;

  int total = 0;
  int bad   = 0;

  serial_seq_gen #(.WIDTH(8), .GAP_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .load(a_load), .din(a_din),
    .ready(a_ready), .x(a_x), .x_valid(a_xv), .done(a_done)
  );

  serial_seq_gen #(.WIDTH(4), .GAP_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .load(b_load), .din(b_din),
    .ready(b_ready), .x(b_x), .x_valid(b_xv), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer-side Moore "101" detector, fed only on x_valid cycles.
  logic [1:0] det_st;
  logic       det_clr;
  wire        det_z = (det_st == 2'd3);
  always @(posedge clk) begin
    if (det_clr) det_st <= 2'd0;
    else if (a_xv) begin
      case (det_st)
        2'd0:    det_st <= a_x ? 2'd1 : 2'd0;
        2'd1:    det_st <= a_x ? 2'd1 : 2'd2;
        2'd2:    det_st <= a_x ? 2'd3 : 2'd0;
        default: det_st <= a_x ? 2'd1 : 2'd2;
      endcase
    end
  end

  task automatic test_reset();
    rst = 1'b0; a_load = 1'b0; b_load = 1'b0; a_din = '0; b_din = '0; det_clr = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({a_ready, a_x, a_xv, a_done} !== 4'b1000) begin
      bad++; $display("FAIL reset_a: got %b want 1000", {a_ready, a_x, a_xv, a_done});
    end
    total++;
    if ({b_ready, b_x, b_xv, b_done} !== 4'b1000) begin
      bad++; $display("FAIL reset_b: got %b want 1000", {b_ready, b_x, b_xv, b_done});
    end
    rst = 1'b1;
    @(negedge clk);
    det_clr = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [10:0] exp = 11'b10110100101;
    a_din = 8'hA5; a_load = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      a_load = 1'b0;
      a_din  = 8'hxx;
      total++;
      if (k < 11) begin
        if ({a_x, a_xv, a_done, a_ready} !== {exp[10-k], 1'b1, (k == 10), 1'b0}) begin
          bad++; $display("FAIL single k=%0d: got x/v/d/r=%b want %b", k,
                          {a_x, a_xv, a_done, a_ready}, {exp[10-k], 1'b1, (k == 10), 1'b0});
        end
      end else if ({a_x, a_xv, a_done, a_ready} !== {3'b000, (k >= 12)}) begin
        bad++; $display("FAIL single_tail k=%0d: got %b want %b", k,
                        {a_x, a_xv, a_done, a_ready}, {3'b000, (k >= 12)});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] f1 = 11'b10111111111;
    logic [10:0] f2 = 11'b10100000000;
    logic [10:0] e;
    a_din = 8'hFF; a_load = 1'b1;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      if (k == 5) a_din = 8'h00;
      if (k == 23) a_load = 1'b0;
      total++;
      if (k < 11 || (k >= 13 && k < 24)) begin
        e = (k < 11) ? f1 : f2;
        if ({a_x, a_xv, a_done, a_ready} !== {e[(k < 11) ? 10-k : 23-k], 1'b1, (k == 10 || k == 23), 1'b0}) begin
          bad++; $display("FAIL b2b k=%0d: got x/v/d/r=%b want %b", k, {a_x, a_xv, a_done, a_ready},
                          {e[(k < 11) ? 10-k : 23-k], 1'b1, (k == 10 || k == 23), 1'b0});
        end
      end else if ({a_xv, a_done, a_ready} !== {2'b00, (k == 12 || k >= 25)}) begin
        bad++; $display("FAIL b2b_gap k=%0d: got v/d/r=%b want %b", k,
                        {a_xv, a_done, a_ready}, {2'b00, (k == 12 || k >= 25)});
      end
    end
  endtask

  task automatic test_ignore_load();
    logic [10:0] exp = 11'b10100111100;
    int ndone = 0;
    a_din = 8'h3C; a_load = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      a_load = (k == 5);
      a_din  = (k == 5) ? 8'hC3 : 8'h3C;
      if (a_done) ndone++;
      total++;
      if (k < 11) begin
        if ({a_x, a_xv} !== {exp[10-k], 1'b1}) begin
          bad++; $display("FAIL ignore k=%0d: got x/v=%b want %b", k, {a_x, a_xv}, {exp[10-k], 1'b1});
        end
      end else if (a_xv !== 1'b0) begin
        bad++; $display("FAIL ignore_tail k=%0d: got x_valid=%b want 0", k, a_xv);
      end
    end
    a_load = 1'b0;
    total++;
    if (ndone != 1) begin
      bad++; $display("FAIL ignore_done: got %0d pulses want 1", ndone);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] exp = 11'b10110000001;
    int ndone = 0;
    a_din = 8'hFF; a_load = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      a_load = 1'b0;
      if (a_done) ndone++;
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({a_x, a_xv, a_done, a_ready} !== 4'b0001) begin
      bad++; $display("FAIL async_clear: got x/v/d/r=%b want 0001", {a_x, a_xv, a_done, a_ready});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({a_xv, a_ready} !== 2'b01 || ndone != 0) begin
      bad++; $display("FAIL post_reset: got v/r=%b done_pulses=%0d want 01/0", {a_xv, a_ready}, ndone);
    end
    a_din = 8'h81; a_load = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      a_load = 1'b0;
      total++;
      if (k < 11) begin
        if ({a_x, a_xv, a_done} !== {exp[10-k], 1'b1, (k == 10)}) begin
          bad++; $display("FAIL fresh k=%0d: got x/v/d=%b want %b", k, {a_x, a_xv, a_done},
                          {exp[10-k], 1'b1, (k == 10)});
        end
      end else if (a_xv !== 1'b0) begin
        bad++; $display("FAIL fresh_tail: got x_valid=%b want 0", a_xv);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_no_gap();
    logic [6:0] exp = 7'b1011001;
    int p;
    b_din = 4'h9; b_load = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      p = k % 8;
      total++;
      if (p < 7) begin
        if ({b_x, b_xv, b_done, b_ready} !== {exp[6-p], 1'b1, (p == 6), 1'b0}) begin
          bad++; $display("FAIL nogap k=%0d: got x/v/d/r=%b want %b", k, {b_x, b_xv, b_done, b_ready},
                          {exp[6-p], 1'b1, (p == 6), 1'b0});
        end
      end else if ({b_xv, b_done, b_ready} !== 3'b001) begin
        bad++; $display("FAIL nogap_idle k=%0d: got v/d/r=%b want 001", k, {b_xv, b_done, b_ready});
      end
    end
    b_load = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_loopback();
    det_clr = 1'b1;
    @(negedge clk);
    det_clr = 1'b0;
    a_din = 8'h50; a_load = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      a_load = 1'b0;
      total++;
      if (det_z !== (k == 3 || k == 5 || k == 7)) begin
        bad++; $display("FAIL loopback_z k=%0d: got %b want %b", k, det_z, (k == 3 || k == 5 || k == 7));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignore_load();
    test_reset_mid_frame();
    test_no_gap();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
